// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-gating sequencer with idle timeout and round-robin wake slot.
// Optional macro CG_STATS_EN adds the saturating gate_off_cnt event counter.
module clock_gate_ctrl #(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned IDLE_CYC = 8,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] busy,
  input  logic [N_DOM-1:0] req,
  input  logic             force_on,
  output logic [N_DOM-1:0] cg_en,
  output logic [N_DOM-1:0] ready
`ifdef CG_STATS_EN
  ,
  output logic [15:0]      gate_off_cnt
`endif
);

  localparam int unsigned PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_e;

  state_e             state_q [N_DOM];
  state_e             state_d [N_DOM];
  logic [CNT_W-1:0]   cnt_q   [N_DOM];
  logic [CNT_W-1:0]   cnt_d   [N_DOM];
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;
  logic [N_DOM-1:0]   cg_en_q;
  logic [N_DOM-1:0]   cg_en_d;
  logic [N_DOM-1:0]   ready_q;
  logic [N_DOM-1:0]   ready_d;

  logic [N_DOM-1:0]   active_c;
  logic [N_DOM-1:0]   grant_c;
  logic               grant_vld_c;
  logic [PTR_W-1:0]   grant_idx_c;
  logic               slot_free_c;

  assign active_c = busy | req | {N_DOM{force_on}};

  // Wake slot: free when nobody is waking or the waking domain finishes this edge.
  always_comb begin
    int unsigned j;
    j           = 0;
    slot_free_c = 1'b1;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    grant_c     = '0;
    for (int unsigned i = 0; i < N_DOM; i++) begin
      if (state_q[i] == ST_WAKE && cnt_q[i] != CNT_W'(WAKE_CYC)) begin
        slot_free_c = 1'b0;
      end
    end
    for (int unsigned k = 0; k < N_DOM; k++) begin
      j = 32'(rr_ptr_q) + k;
      if (j >= N_DOM) begin
        j = j - N_DOM;
      end
      if (slot_free_c && !grant_vld_c &&
          state_q[PTR_W'(j)] == ST_OFF && active_c[PTR_W'(j)]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = PTR_W'(j);
      end
    end
    if (grant_vld_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld_c) begin
      rr_ptr_d = (grant_idx_c == PTR_W'(N_DOM - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end
  end

  // Per-domain next state; cg_en/ready are registered copies of the next state.
  always_comb begin
    for (int unsigned i = 0; i < N_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_ON: begin
          if (!active_c[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (active_c[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(IDLE_CYC - 1)) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (grant_c[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        ST_WAKE: begin
          if (cnt_q[i] == CNT_W'(WAKE_CYC)) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_ON;
          cnt_d[i]   = '0;
        end
      endcase
      cg_en_d[i] = (state_d[i] != ST_OFF);
      ready_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_DOM; i++) begin
        state_q[i] <= ST_ON;
        cnt_q[i]   <= '0;
      end
      rr_ptr_q <= '0;
      cg_en_q  <= '1;
      ready_q  <= '1;
    end else begin
      for (int unsigned i = 0; i < N_DOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      cg_en_q  <= cg_en_d;
      ready_q  <= ready_d;
    end
  end

  assign cg_en = cg_en_q;
  assign ready = ready_q;

`ifdef CG_STATS_EN
  logic [15:0] gate_off_cnt_q;
  logic [15:0] gate_off_cnt_d;
  logic [15:0] n_off_c;
  logic [16:0] sum_c;

  // Saturating count of domains entering OFF on each edge.
  always_comb begin
    n_off_c = '0;
    for (int unsigned i = 0; i < N_DOM; i++) begin
      if (state_q[i] == ST_IDLE && state_d[i] == ST_OFF) begin
        n_off_c = n_off_c + 16'(1);
      end
    end
    sum_c          = {1'b0, gate_off_cnt_q} + {1'b0, n_off_c};
    gate_off_cnt_d = sum_c[16] ? 16'hFFFF : sum_c[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_off_cnt_q <= '0;
    end else begin
      gate_off_cnt_q <= gate_off_cnt_d;
    end
  end

  assign gate_off_cnt = gate_off_cnt_q;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: directed scenarios plus randomized traffic
// compared against an idle-run / wake-age reference model.
module tb_clock_gate_ctrl;
  localparam int N        = 4;
  localparam int IDLE_CYC = 8;
  localparam int WAKE_CYC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] busy;
  logic [N-1:0] req;
  logic         force_on;
  logic [N-1:0] cg_en;
  logic [N-1:0] ready;
`ifdef CG_STATS_EN
  logic [15:0]  gate_off_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  clock_gate_ctrl #(
    .N_DOM(N), .IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .busy(busy), .req(req), .force_on(force_on),
    .cg_en(cg_en), .ready(ready)
`ifdef CG_STATS_EN
    , .gate_off_cnt(gate_off_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a running clock accumulates an idle run; a waking domain ages.
  int           run_idle [N];
  bit           gated    [N];
  int           wake_age [N];
  int           m_rr;
  int           m_goff;
  logic [N-1:0] m_cg_en;
  logic [N-1:0] m_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_cg_en[i] = !gated[i];
      m_ready[i] = !gated[i] && (wake_age[i] == 0);
    end
  end

  always @(posedge clk) begin : ref_model
    int  nx_run   [N];
    bit  nx_gated [N];
    int  nx_age   [N];
    bit  act      [N];
    int  waker, granted, j, n_off;
    bit  free;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        run_idle[i] <= 0;
        gated[i]    <= 1'b0;
        wake_age[i] <= 0;
      end
      m_rr   <= 0;
      m_goff <= 0;
    end else begin
      waker = -1;
      for (int i = 0; i < N; i++) begin
        act[i] = busy[i] | req[i] | force_on;
        if (wake_age[i] != 0) waker = i;
      end
      if (waker >= 0) free = (wake_age[waker] == WAKE_CYC);
      else free = 1'b1;
      granted = -1;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (granted < 0 && gated[j] && act[j]) granted = j;
        end
      end
      n_off = 0;
      for (int i = 0; i < N; i++) begin
        nx_run[i]   = run_idle[i];
        nx_gated[i] = gated[i];
        nx_age[i]   = wake_age[i];
        if (wake_age[i] != 0) begin
          nx_age[i] = (wake_age[i] == WAKE_CYC) ? 0 : wake_age[i] + 1;
          nx_run[i] = 0;
        end else if (!gated[i]) begin
          nx_run[i] = act[i] ? 0 : run_idle[i] + 1;
          if (nx_run[i] == IDLE_CYC) begin
            nx_gated[i] = 1'b1;
            nx_run[i]   = 0;
            n_off++;
          end
        end else if (i == granted) begin
          nx_gated[i] = 1'b0;
          nx_age[i]   = 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        run_idle[i] <= nx_run[i];
        gated[i]    <= nx_gated[i];
        wake_age[i] <= nx_age[i];
      end
      if (granted >= 0) m_rr <= (granted + 1) % N;
      m_goff <= (m_goff + n_off > 65535) ? 65535 : m_goff + n_off;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; busy = '0; req = '0; force_on = 1'b0;
    tick();
    tick();
    n_checks++;
    if (cg_en !== 4'b1111 || ready !== 4'b1111)
      $display("FAIL reset_outputs: cg_en=%b ready=%b expected 1111/1111", cg_en, ready);
    else n_pass++;
`ifdef CG_STATS_EN
    n_checks++;
    if (gate_off_cnt !== 16'd0)
      $display("FAIL reset_gate_off_cnt: got %0d expected 0", gate_off_cnt);
    else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_idle_timeout();
    busy = 4'b1110;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_checks++;
      if (cg_en[0] !== (e < 7) || cg_en !== m_cg_en || ready !== m_ready)
        $display("FAIL idle_timeout edge %0d: cg_en=%b ready=%b expected %b/%b",
                 e, cg_en, ready, m_cg_en, m_ready);
      else n_pass++;
    end
`ifdef CG_STATS_EN
    n_checks++;
    if (gate_off_cnt !== 16'd1)
      $display("FAIL idle_timeout_cnt: got %0d expected 1", gate_off_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_idle_restart();
    do_reset();
    busy = 4'b1110;
    repeat (5) tick();
    busy = 4'b1111;
    tick();
    busy = 4'b1110;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (cg_en[0] !== (k < 8) || cg_en !== m_cg_en || ready !== m_ready)
        $display("FAIL idle_restart step %0d: cg_en=%b ready=%b expected cg_en[0]=%b",
                 k, cg_en, ready, (k < 8));
      else n_pass++;
    end
  endtask

  task automatic test_single_wake();
    logic [2:0] exp_rdy [3];
    exp_rdy[0] = 3'b000; exp_rdy[1] = 3'b000; exp_rdy[2] = 3'b001;
    do_reset();
    busy = 4'b1101;
    repeat (8) tick();
    n_checks++;
    if (cg_en !== 4'b1101) $display("FAIL single_wake_off: cg_en=%b expected 1101", cg_en);
    else n_pass++;
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      req = '0;
      n_checks++;
      if (cg_en[1] !== 1'b1 || ready[1] !== exp_rdy[k][0] || ready !== m_ready)
        $display("FAIL single_wake E+%0d: cg_en[1]=%b ready[1]=%b expected 1/%b",
                 k, cg_en[1], ready[1], exp_rdy[k][0]);
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_en, exp_rdy;
    do_reset();
    busy = '0; req = '0;
    repeat (8) tick();
    n_checks++;
    if (cg_en !== 4'b0000 || ready !== 4'b0000)
      $display("FAIL contention_all_off: cg_en=%b ready=%b expected 0000/0000", cg_en, ready);
    else n_pass++;
    req = 4'b1111;
    for (int t = 0; t < 10; t++) begin
      tick();
      for (int d = 0; d < N; d++) begin
        exp_en[d]  = (t >= 2 * d);
        exp_rdy[d] = (t >= 2 * d + 2);
      end
      n_checks++;
      if (cg_en !== exp_en || ready !== exp_rdy || $countones(cg_en & ~ready) > 1)
        $display("FAIL contention E+%0d: cg_en=%b ready=%b expected %b/%b",
                 t, cg_en, ready, exp_en, exp_rdy);
      else n_pass++;
    end
    req = '0;
    repeat (9) tick();
    req = 4'b1001;
    tick();
    n_checks++;
    if (cg_en !== 4'b0001)
      $display("FAIL contention_rr_end: cg_en=%b expected 0001", cg_en);
    else n_pass++;
`ifdef CG_STATS_EN
    n_checks++;
    if (gate_off_cnt !== 16'd8)
      $display("FAIL contention_cnt: got %0d expected 8", gate_off_cnt);
    else n_pass++;
`endif
    req = '0;
  endtask

  task automatic test_reset_mid_wake();
    do_reset();
    busy = '0; req = '0;
    repeat (8) tick();
    req = 4'b1000;
    tick();
    req = 4'b0100;
    repeat (2) tick();
    tick();
    n_checks++;
    if (cg_en !== 4'b1100 || ready !== 4'b1000)
      $display("FAIL mid_wake_setup: cg_en=%b ready=%b expected 1100/1000", cg_en, ready);
    else n_pass++;
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    n_checks++;
    if (cg_en !== 4'b1111 || ready !== 4'b1111)
      $display("FAIL mid_wake_reset: cg_en=%b ready=%b expected 1111/1111", cg_en, ready);
    else n_pass++;
    repeat (8) tick();
    req = 4'b1111;
    tick();
    n_checks++;
    if (cg_en !== 4'b0001 || ready !== 4'b0000)
      $display("FAIL mid_wake_rr_cleared: cg_en=%b ready=%b expected 0001/0000", cg_en, ready);
    else n_pass++;
    req = '0;
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    dens = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) dens = int'($urandom_range(2, 24));
      rst      = ($urandom_range(0, 599) == 0);
      force_on = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 2 * dens) == 0);
        busy[i] = m_cg_en[i] && ($urandom_range(0, dens) == 0);
      end
      tick();
      n_checks++;
      if (cg_en !== m_cg_en || ready !== m_ready || $countones(cg_en & ~ready) > 1)
        $display("FAIL random cycle %0d: cg_en=%b ready=%b expected %b/%b",
                 c, cg_en, ready, m_cg_en, m_ready);
      else n_pass++;
`ifdef CG_STATS_EN
      n_checks++;
      if (gate_off_cnt !== 16'(m_goff))
        $display("FAIL random_cnt cycle %0d: got %0d expected %0d", c, gate_off_cnt, m_goff);
      else n_pass++;
`endif
    end
    rst = 1'b0; force_on = 1'b0; busy = '0; req = '0;
  endtask

  initial begin
    rst = 1'b1; busy = '0; req = '0; force_on = 1'b0;
    test_reset();
    test_idle_timeout();
    test_idle_restart();
    test_single_wake();
    test_contention();
    test_reset_mid_wake();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
